// File: rtl/fifo_write_arbiter_if.sv
// Write-port bundle between the requesters / FIFO and the burst arbiter.
// master: the arbiter side; slave: the requester / FIFO side.
//
// Handshake: while the arbiter is in GRANT, a word from the owner is accepted
// on each clock edge where ack[owner] (= write_enable) is high. A requester holds
// req high while it has data. It may change req_data and req_last only after an
// ack cycle or while its gnt bit is low. Dropping req ends the burst.
interface fifo_write_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
);
  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_last;
  logic                      fifo_full;
  logic [NUM_REQ-1:0]        gnt;
  logic [NUM_REQ-1:0]        ack;
  logic                      write_enable;
  logic [DATA_W-1:0]         trans_data;
  logic [IDW-1:0]            owner_id;
  logic                      busy;

  modport master (
    input  req, req_data, req_last, fifo_full,
    output gnt, ack, write_enable, trans_data, owner_id, busy
  );

  modport slave (
    output req, req_data, req_last, fifo_full,
    input  gnt, ack, write_enable, trans_data, owner_id, busy
  );
endinterface

// File: rtl/fifo_write_arbiter.sv
// Round-robin burst arbiter for the FIFO write port (trans_clk domain).
// A grant is held for up to BURST_MAX accepted words, or until the owner's
// last word, or until the owner drops req. A full FIFO stalls the burst but
// never breaks it.
// Optional statistics counters are enabled with the WR_ARB_STATS_EN macro.
module fifo_write_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 8,
  parameter int BURST_MAX = 4
) (
  input  logic                trans_clk,
  input  logic                trans_rst,
  fifo_write_arbiter_if.master bus
`ifdef WR_ARB_STATS_EN
  ,
  output logic [15:0]         stall_cnt,
  output logic [15:0]         grant_cnt
`endif
);
  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW  = $clog2(BURST_MAX + 1);

  typedef enum logic {ST_ARB, ST_GRANT} state_t;

  state_t             state_q;
  logic [NUM_REQ-1:0] gnt_q;
  logic [IDW-1:0]     owner_q;
  logic [IDW-1:0]     ptr_q;
  logic [CW-1:0]      cnt_q;

  logic               any_req;
  logic               found;
  logic [IDW-1:0]     sel;
  logic               owner_req;
  logic               owner_last;
  logic               write_en;
  logic               last_beat;

  // Pick the first requester above the pointer, wrapping, so the previous owner ranks last.
  always_comb begin
    any_req = |bus.req;
    found   = 1'b0;
    sel     = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!found && bus.req[(int'(ptr_q) + k) % NUM_REQ]) begin
        found = 1'b1;
        sel   = IDW'((int'(ptr_q) + k) % NUM_REQ);
      end
    end
  end

  // Owner-side write path: data always follows the owner, write only when it has data and the FIFO has room.
  always_comb begin
    owner_req        = bus.req[owner_q];
    owner_last       = bus.req_last[owner_q];
    write_en         = (state_q == ST_GRANT) && owner_req && !bus.fifo_full;
    last_beat        = owner_last || (({1'b0, cnt_q} + 1'b1) == (CW+1)'(BURST_MAX));
    bus.write_enable = write_en;
    bus.ack          = write_en ? gnt_q : '0;
    bus.trans_data   = bus.req_data[int'(owner_q) * DATA_W +: DATA_W];
    bus.gnt          = gnt_q;
    bus.owner_id     = owner_q;
    bus.busy         = (state_q == ST_GRANT);
  end

  // Arbitration / burst FSM with registered grant, owner and burst counter.
  always_ff @(posedge trans_clk or negedge trans_rst) begin
    if (!trans_rst) begin
      state_q <= ST_ARB;
      gnt_q   <= '0;
      owner_q <= '0;
      ptr_q   <= IDW'(NUM_REQ - 1);
      cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_ARB: begin
          if (any_req) begin
            state_q <= ST_GRANT;
            gnt_q   <= {{(NUM_REQ-1){1'b0}}, 1'b1} << sel;
            owner_q <= sel;
            ptr_q   <= sel;
            cnt_q   <= '0;
          end
        end
        ST_GRANT: begin
          if (!owner_req) begin
            state_q <= ST_ARB;
            gnt_q   <= '0;
            owner_q <= '0;
          end else if (write_en) begin
            cnt_q <= cnt_q + 1'b1;
            if (last_beat) begin
              state_q <= ST_ARB;
              gnt_q   <= '0;
              owner_q <= '0;
            end
          end
        end
        default: begin
          state_q <= ST_ARB;
          gnt_q   <= '0;
          owner_q <= '0;
        end
      endcase
    end
  end

`ifdef WR_ARB_STATS_EN
  // Saturating counters: cycles the owner is blocked by a full FIFO, and grants issued.
  always_ff @(posedge trans_clk or negedge trans_rst) begin
    if (!trans_rst) begin
      stall_cnt <= '0;
      grant_cnt <= '0;
    end else begin
      if ((state_q == ST_GRANT) && owner_req && bus.fifo_full && (stall_cnt != 16'hFFFF))
        stall_cnt <= stall_cnt + 16'd1;
      if ((state_q == ST_ARB) && any_req && (grant_cnt != 16'hFFFF))
        grant_cnt <= grant_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter (NUM_REQ=4, DATA_W=8, BURST_MAX=4).
module tb_fifo_write_arbiter;
  logic trans_clk;
  logic trans_rst;
  int   checks;
  int   errors;

  fifo_write_arbiter_if #(.NUM_REQ(4), .DATA_W(8)) bus ();

`ifdef WR_ARB_STATS_EN
  logic [15:0] stall_cnt;
  logic [15:0] grant_cnt;
`endif

  fifo_write_arbiter #(.NUM_REQ(4), .DATA_W(8), .BURST_MAX(4)) dut (
    .trans_clk (trans_clk),
    .trans_rst (trans_rst),
    .bus       (bus)
`ifdef WR_ARB_STATS_EN
    ,
    .stall_cnt (stall_cnt),
    .grant_cnt (grant_cnt)
`endif
  );

  // Clock: posedge at 5, 15, 25, ...
  initial begin
    trans_clk = 1'b0;
    forever #5 trans_clk = ~trans_clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to 2 time units after the next rising edge.
  task automatic tick();
    @(posedge trans_clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_data(input int i, input logic [7:0] v);
    bus.req_data[i*8 +: 8] = v;
  endtask

  task automatic rst_pulse();
    trans_rst = 1'b0;
    #1;
    trans_rst = 1'b1;
  endtask

  initial begin
    logic [3:0] oh;
    checks        = 0;
    errors        = 0;
    trans_rst     = 1'b0;
    bus.req       = '0;
    bus.req_data  = '0;
    bus.req_last  = '0;
    bus.fifo_full = 1'b0;

    // Reset values
    #1;
    chk("rst_gnt", bus.gnt, 4'b0000);
    chk("rst_we", bus.write_enable, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_owner", bus.owner_id, 2'd0);
    #2 trans_rst = 1'b1;
    tick();

    // Single requester, 3-word burst ending on req_last
    bus.req = 4'b0001;
    set_data(0, 8'hA1);
    settle();
    chk("s1_arb_we", bus.write_enable, 1'b0);
    tick();
    settle();
    chk("s1_gnt", bus.gnt, 4'b0001);
    chk("s1_busy", bus.busy, 1'b1);
    chk("s1_ack0", bus.ack, 4'b0001);
    chk("s1_data0", bus.trans_data, 8'hA1);
    tick();
    set_data(0, 8'hA2);
    settle();
    chk("s1_ack1", bus.ack, 4'b0001);
    chk("s1_data1", bus.trans_data, 8'hA2);
    tick();
    set_data(0, 8'hA3);
    bus.req_last = 4'b0001;
    settle();
    chk("s1_ack2", bus.ack, 4'b0001);
    chk("s1_data2", bus.trans_data, 8'hA3);
    tick();
    bus.req      = '0;
    bus.req_last = '0;
    settle();
    chk("s1_end_gnt", bus.gnt, 4'b0000);
    chk("s1_end_busy", bus.busy, 1'b0);
    chk("s1_end_we", bus.write_enable, 1'b0);

    // All four requesting: grants 0,1,2,3,0 of 4 words each, one idle cycle between
    rst_pulse();
    bus.req = 4'b1111;
    for (int i = 0; i < 4; i++) set_data(i, 8'hB0 + 8'(i));
    settle();
    chk("s2_first_arb_we", bus.write_enable, 1'b0);
    tick();
    for (int g = 0; g < 5; g++) begin
      oh = 4'b0001 << (g % 4);
      for (int w = 0; w < 4; w++) begin
        settle();
        chk($sformatf("s2_g%0d_w%0d_gnt", g, w), bus.gnt, oh);
        chk($sformatf("s2_g%0d_w%0d_ack", g, w), bus.ack, oh);
        chk($sformatf("s2_g%0d_w%0d_data", g, w), bus.trans_data, 8'hB0 + 8'(g % 4));
        tick();
      end
      settle();
      chk($sformatf("s2_g%0d_idle_gnt", g), bus.gnt, 4'b0000);
      chk($sformatf("s2_g%0d_idle_we", g), bus.write_enable, 1'b0);
      tick();
    end
    bus.req = '0;
    settle();
    chk("s2_drop_we", bus.write_enable, 1'b0);
    tick();

    // Owner 2 stalled by a full FIFO for 5 cycles mid-burst
    bus.req = 4'b0100;
    set_data(2, 8'hC0);
    tick();
    settle();
    chk("s3_gnt", bus.gnt, 4'b0100);
    chk("s3_ack0", bus.ack, 4'b0100);
    chk("s3_data0", bus.trans_data, 8'hC0);
    tick();
    set_data(2, 8'hC1);
    settle();
    chk("s3_ack1", bus.ack, 4'b0100);
    tick();
    set_data(2, 8'hC2);
    bus.fifo_full = 1'b1;
    for (int s = 0; s < 5; s++) begin
      settle();
      chk($sformatf("s3_stall%0d_ack", s), bus.ack, 4'b0000);
      chk($sformatf("s3_stall%0d_we", s), bus.write_enable, 1'b0);
      chk($sformatf("s3_stall%0d_gnt", s), bus.gnt, 4'b0100);
      tick();
    end
    bus.fifo_full = 1'b0;
    settle();
    chk("s3_ack2", bus.ack, 4'b0100);
    chk("s3_data2", bus.trans_data, 8'hC2);
    tick();
    set_data(2, 8'hC3);
    settle();
    chk("s3_ack3", bus.ack, 4'b0100);
    chk("s3_data3", bus.trans_data, 8'hC3);
    tick();
    settle();
    chk("s3_end_gnt", bus.gnt, 4'b0000);
    chk("s3_end_we", bus.write_enable, 1'b0);
    bus.req = '0;

    // Owner 1 drops req after 2 words; requester 3 is next
    rst_pulse();
    bus.req = 4'b1010;
    set_data(1, 8'hD0);
    set_data(3, 8'hE0);
    tick();
    settle();
    chk("s4_gnt", bus.gnt, 4'b0010);
    chk("s4_owner", bus.owner_id, 2'd1);
    chk("s4_ack0", bus.ack, 4'b0010);
    tick();
    set_data(1, 8'hD1);
    settle();
    chk("s4_ack1", bus.ack, 4'b0010);
    chk("s4_data1", bus.trans_data, 8'hD1);
    tick();
    bus.req = 4'b1000;
    settle();
    chk("s4_drop_ack", bus.ack, 4'b0000);
    chk("s4_drop_we", bus.write_enable, 1'b0);
    tick();
    settle();
    chk("s4_arb_gnt", bus.gnt, 4'b0000);
    chk("s4_arb_busy", bus.busy, 1'b0);
    tick();
    settle();
    chk("s4_next_gnt", bus.gnt, 4'b1000);
    chk("s4_next_owner", bus.owner_id, 2'd3);
    chk("s4_next_data", bus.trans_data, 8'hE0);

    // Asynchronous reset between edges in the middle of owner 3's burst
    bus.req = 4'b1001;
    set_data(0, 8'hF0);
    settle();
    chk("s5_ack", bus.ack, 4'b1000);
    tick();
    trans_rst = 1'b0;
    #1;
    chk("s5_rst_gnt", bus.gnt, 4'b0000);
    chk("s5_rst_we", bus.write_enable, 1'b0);
    chk("s5_rst_busy", bus.busy, 1'b0);
    chk("s5_rst_ack", bus.ack, 4'b0000);
    chk("s5_rst_owner", bus.owner_id, 2'd0);
    #1 trans_rst = 1'b1;
    tick();
    settle();
    chk("s5_regrant_gnt", bus.gnt, 4'b0001);
    chk("s5_regrant_data", bus.trans_data, 8'hF0);

`ifdef WR_ARB_STATS_EN
    // Statistics: 10 stall cycles and 3 grants, then saturation of stall_cnt
    bus.req = '0;
    rst_pulse();
    settle();
    chk("st_rst_stall", stall_cnt, 16'd0);
    chk("st_rst_grant", grant_cnt, 16'd0);
    bus.req       = 4'b0001;
    bus.req_last  = 4'b0001;
    bus.fifo_full = 1'b1;
    tick();
    repeat (10) tick();
    bus.fifo_full = 1'b0;
    settle();
    chk("st_we", bus.write_enable, 1'b1);
    tick();
    tick();
    tick();
    tick();
    bus.req = '0;
    tick();
    settle();
    chk("st_stall10", stall_cnt, 16'd10);
    chk("st_grant3", grant_cnt, 16'd3);
    bus.req       = 4'b0001;
    bus.req_last  = '0;
    bus.fifo_full = 1'b1;
    tick();
    repeat (70000) @(posedge trans_clk);
    #2;
    chk("st_stall_sat", stall_cnt, 16'hFFFF);
    chk("st_grant4", grant_cnt, 16'd4);
    bus.fifo_full = 1'b0;
    bus.req       = '0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
